// File: rtl/memory_dual_pipe.sv
// Simple-dual-port RAM with byte enables, RD_LATENCY-deep read pipeline and a zero-fill clear engine.
// Optional macro MEM_RAW_BYPASS_EN: same-cycle same-address read sees the merged write word.
module memory_dual_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  init_busy,
    input  logic                  wr_cs,
    input  logic [BE_WIDTH-1:0]   wr_be,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_cs,
    input  logic                  rd_oe,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    // Range compare done one bit wider so a full-depth array still compares cleanly.
    localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic                    idle;
    logic                    wr_in_range, rd_in_range;
    logic                    wr_en, rd_req;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic [RD_LATENCY:1]                 vld_pipe;
    logic [RD_LATENCY:1][DATA_WIDTH-1:0] dat_pipe;

    assign idle        = (state_q == ST_IDLE);
    assign init_busy   = (state_q == ST_CLEAR);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
    assign wr_en       = idle && wr_cs && wr_in_range;
    assign rd_req      = idle && rd_cs && rd_oe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
                if (clr_ptr_q == LAST_PTR) state_d = ST_IDLE;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Array has no reset; the clear engine owns the write port while busy.
    always_ff @(posedge clk) begin
        if (!idle) begin
            mem[clr_ptr_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
`ifdef MEM_RAW_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr)) begin
                for (int i = 0; i < BE_WIDTH; i++) begin
                    if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
`endif
        end
    end

    // Invalid stages always carry zero data, so the output needs no final mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_req;
            dat_pipe[1] <= rd_req ? rd_word : '0;
            for (int s = 2; s <= RD_LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign rd_valid = vld_pipe[RD_LATENCY];
    assign rd_data  = dat_pipe[RD_LATENCY];

endmodule

// File: tb/tb_memory_dual_pipe.sv
// Scoreboard bench: five RAMs share one stimulus stream (latency 1..4 at depth 256, latency 1 at depth 200).
module tb_memory_dual_pipe;

    localparam int NI = 5;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, clear_req, wr_cs, rd_cs, rd_oe;
    logic [3:0]  wr_be;
    logic [7:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;

    logic        init_busy_w [NI];
    logic        rd_valid_w  [NI];
    logic [31:0] rd_data_w   [NI];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q [NI][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(int k);
        return (k == 4) ? 1 : k + 1;
    endfunction

    function automatic int depth_of(int k);
        return (k == 4) ? 200 : 256;
    endfunction

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            memory_dual_pipe #(
                .DATA_WIDTH(32),
                .ADDR_WIDTH(8),
                .RAM_DEPTH ((g == 4) ? 200 : 256),
                .RD_LATENCY((g == 4) ? 1 : g + 1)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .clear_req(clear_req),
                .init_busy(init_busy_w[g]),
                .wr_cs    (wr_cs),
                .wr_be    (wr_be),
                .wr_addr  (wr_addr),
                .wr_data  (wr_data),
                .rd_cs    (rd_cs),
                .rd_oe    (rd_oe),
                .rd_addr  (rd_addr),
                .rd_data  (rd_data_w[g]),
                .rd_valid (rd_valid_w[g])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (sb_q[k].size() > 0 && sb_q[k][0].due < cyc) begin
                    e = sb_q[k].pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_rd_valid[%0d]: none by cycle %0d, required at cycle %0d (data %h)",
                             k, cyc, e.due, e.data);
                end
                if (rd_valid_w[k]) begin
                    if (sb_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rd_valid[%0d]: rd_valid=1 data %h at cycle %0d, required rd_valid=0",
                                 k, rd_data_w[k], cyc);
                    end else begin
                        e = sb_q[k].pop_front();
                        chk($sformatf("rd_data[%0d]", k), rd_data_w[k], e.data);
                        chk($sformatf("rd_cycle[%0d]", k), cyc, e.due);
                    end
                end else begin
                    chk($sformatf("rd_data_idle_zero[%0d]", k), rd_data_w[k], 32'h0);
                end
            end
        end
    endtask

    task automatic clr_in();
        wr_cs = 1'b0; rd_cs = 1'b0; rd_oe = 1'b0; clear_req = 1'b0; wr_be = 4'h0;
    endtask

    task automatic tick();
        @(negedge clk);
        clr_in();
    endtask

    task automatic set_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_cs = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    endtask

    // e_a: expectation for the depth-256 RAMs, e_b: for the depth-200 RAM.
    task automatic set_rd(input logic [7:0] a, input logic [31:0] e_a, input logic [31:0] e_b);
        exp_t e;
        rd_cs = 1'b1; rd_oe = 1'b1; rd_addr = a;
        for (int k = 0; k < NI; k++) begin
            e.data = (k == 4) ? e_b : e_a;
            e.due  = cyc + lat_of(k);
            sb_q[k].push_back(e);
        end
    endtask

    task automatic drain();
        repeat (8) tick();
    endtask

    // Counts cycles until each clear finishes; optionally holds reads and pokes clear_req/write mid-clear.
    task automatic measure_busy(input bit hold_rd, input int poke);
        int d [NI];
        int n;
        bit done;
        for (int k = 0; k < NI; k++) d[k] = -1;
        n = 0;
        done = 1'b0;
        while (!done && n < 700) begin
            if (hold_rd && n < 150) begin
                rd_cs = 1'b1; rd_oe = 1'b1; rd_addr = 8'(n);
            end else begin
                rd_cs = 1'b0; rd_oe = 1'b0;
            end
            if (n == poke) begin
                clear_req = 1'b1;
                set_wr(8'd0, 32'h0000_0099, 4'hF);
            end else begin
                clear_req = 1'b0; wr_cs = 1'b0;
            end
            @(negedge clk);
            n++;
            done = 1'b1;
            for (int k = 0; k < NI; k++) begin
                if (d[k] < 0 && !init_busy_w[k]) d[k] = n;
                if (d[k] < 0) done = 1'b0;
            end
        end
        clr_in();
        for (int k = 0; k < NI; k++)
            chk($sformatf("init_busy_cycles[%0d]", k), d[k], depth_of(k));
    endtask

    task automatic chk_reset_state(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s_init_busy[%0d]", tag, k), {31'h0, init_busy_w[k]}, 32'h1);
            chk($sformatf("%s_rd_valid[%0d]", tag, k), {31'h0, rd_valid_w[k]}, 32'h0);
            chk($sformatf("%s_rd_data[%0d]", tag, k), rd_data_w[k], 32'h0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clr_in();
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog: simulation did not finish within time limit");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Power-up reset and initial clear
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        measure_busy(1'b0, -1);
        set_rd(8'd0,   32'h0, 32'h0); tick();
        set_rd(8'd17,  32'h0, 32'h0); tick();
        set_rd(8'd255, 32'h0, 32'h0); tick();
        drain();

        // Byte enables
        set_wr(8'd5, 32'hAABB_CCDD, 4'b1111); tick();
        set_wr(8'd5, 32'h1122_3344, 4'b0101); tick();
        set_rd(8'd5, 32'hAA22_CC44, 32'hAA22_CC44); tick();

        // Latency and back-to-back reads
        set_wr(8'd3, 32'hDEAD_BEEF, 4'hF); tick();
        set_wr(8'd4, 32'h0000_0004, 4'hF); tick();
        set_rd(8'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF); tick();
        set_rd(8'd4, 32'h0000_0004, 32'h0000_0004); tick();
        drain();

        // Same-cycle read/write of one address
        set_wr(8'd9, 32'h1234_5678, 4'hF); tick();
        set_wr(8'd9, 32'hFFFF_FFFF, 4'b0011);
`ifdef MEM_RAW_BYPASS_EN
        set_rd(8'd9, 32'h1234_FFFF, 32'h1234_FFFF); tick();
`else
        set_rd(8'd9, 32'h1234_5678, 32'h1234_5678); tick();
`endif
        set_rd(8'd9, 32'h1234_FFFF, 32'h1234_FFFF); tick();
        set_wr(8'd6, 32'h0BAD_0BAD, 4'hF);
        set_rd(8'd5, 32'hAA22_CC44, 32'hAA22_CC44); tick();
        set_rd(8'd6, 32'h0BAD_0BAD, 32'h0BAD_0BAD); tick();

        // Read gating and empty byte enable
        rd_cs = 1'b1; rd_oe = 1'b0; rd_addr = 8'd9; tick();
        rd_cs = 1'b0; rd_oe = 1'b1; rd_addr = 8'd9; tick();
        set_wr(8'd9, 32'h0000_0000, 4'h0); tick();
        set_rd(8'd9, 32'h1234_FFFF, 32'h1234_FFFF); tick();
        drain();

        // Address bounds (depth 200 instance drops/zeros 200..255)
        set_wr(8'd210, 32'h0000_CAFE, 4'hF); tick();
        set_rd(8'd210, 32'h0000_CAFE, 32'h0); tick();
        set_wr(8'd199, 32'h0000_0077, 4'hF); tick();
        set_wr(8'd200, 32'h0000_ABCD, 4'hF); tick();
        set_rd(8'd199, 32'h0000_0077, 32'h0000_0077); tick();
        set_rd(8'd200, 32'h0000_ABCD, 32'h0); tick();
        set_rd(8'd10,  32'h0, 32'h0); tick();
        set_rd(8'd5,   32'hAA22_CC44, 32'hAA22_CC44); tick();
        set_rd(8'd3,   32'hDEAD_BEEF, 32'hDEAD_BEEF); tick();
        drain();

        // clear_req: same-cycle read/write accepted, mid-clear clear_req/write/reads ignored
        set_wr(8'd200, 32'h0000_0055, 4'hF); tick();
        clear_req = 1'b1;
        set_wr(8'd7, 32'h0000_0070, 4'hF);
        set_rd(8'd5, 32'hAA22_CC44, 32'hAA22_CC44); tick();
        measure_busy(1'b1, 50);
        set_rd(8'd200, 32'h0, 32'h0); tick();
        set_rd(8'd0,   32'h0, 32'h0); tick();
        set_rd(8'd7,   32'h0, 32'h0); tick();
        set_rd(8'd5,   32'h0, 32'h0); tick();
        drain();

        // Reset mid-clear restarts the full clear
        set_wr(8'd4, 32'h0000_0444, 4'hF); tick();
        rst_n = 1'b0;
        #1 chk_reset_state("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 100; n++) begin
            rd_cs = 1'b1; rd_oe = 1'b1; rd_addr = 8'(n);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1 chk_reset_state("midclear_reset");
        @(negedge clk);
        rst_n = 1'b1;
        clr_in();
        measure_busy(1'b1, -1);
        set_wr(8'd3, 32'h0000_0001, 4'hF); tick();
        set_rd(8'd3, 32'h0000_0001, 32'h0000_0001); tick();
        set_rd(8'd4, 32'h0, 32'h0); tick();
        drain();

        for (int k = 0; k < NI; k++)
            chk($sformatf("scoreboard_empty[%0d]", k), sb_q[k].size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_dual_pipe.md
Name: memory_dual_pipe

Overview:
- Parametrised simple-dual-port synchronous RAM: one write port and one read port, used as the hypervector/scratch store in the accelerator datapath.
- Generalises the single-port RAM with the following additions:
  - independent read and write ports
  - per-byte write enables
  - configurable read latency with a valid strobe
  - a hardware clear engine that zeroes the array after reset or on request

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width.
- RAM_DEPTH, 1 << ADDR_WIDTH, number of words; must be ≤ 2^ADDR_WIDTH.
- RD_LATENCY, 1, cycles from read request to rd_valid; legal range 1..4.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width (derived, do not override).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- clear_req  in  1  pulse; starts an array clear when IDLE.
- init_busy  out  1  high while the clear engine runs.
- wr_cs  in  1  write port chip select.
- wr_be  in  BE_WIDTH  byte write enables; bit i covers data bits [8i+7:8i].
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_cs  in  1  read port chip select.
- rd_oe  in  1  read output enable.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data; zero when rd_valid=0.
- rd_valid  out  1  qualifies rd_data.

Behaviour:
- Reset (rst_n low, async):
  - FSM goes to CLEAR, clear pointer = 0, init_busy=1.
  - All read pipeline stages invalidated: rd_valid=0, rd_data=0.
  - Array contents are undefined until the clear completes.
- FSM states:
  - IDLE: normal operation.
    - clear_req=1 → CLEAR, pointer=0. Any write/read in that same cycle is still accepted.
  - CLEAR: each cycle writes all-zero to mem[pointer] and increments pointer.
    - When pointer == RAM_DEPTH-1 the write completes, then → IDLE and init_busy drops the next cycle.
    - Clear of the full depth takes exactly RAM_DEPTH cycles.
    - While in CLEAR: external writes are dropped, read requests are ignored (no rd_valid), clear_req is ignored.
  - Reset asserted mid-clear restarts the clear from address 0.
- Write (IDLE only): when wr_cs=1, mem[wr_addr] byte i is updated from wr_data for every wr_be[i]=1; other bytes hold. wr_be=0 is a no-op.
- Read request is accepted when IDLE && rd_cs && rd_oe.
- Read pipeline:
  - Stage 1 captures mem[rd_addr] and a valid bit; stages 2..RD_LATENCY are pure registers.
  - rd_valid/rd_data appear exactly RD_LATENCY cycles after the request edge.
  - Fully pipelined: one read per cycle, no stalls.
  - When a stage's valid bit is 0, its data is forced to 0.
- Address bounds: an address ≥ RAM_DEPTH is out of range.
  - Writes to it are dropped.
  - Reads of it return rd_data=0 with rd_valid=1, at normal latency.
- Same-address read and write in the same cycle: the read returns the pre-write contents unless MEM_RAW_BYPASS_EN is defined.
- Reads issued in the cycle before init_busy falls are ignored; the first legal read is the one issued when init_busy=0.

Optional Feature:
- Macro: MEM_RAW_BYPASS_EN.
- Defined: a read and a write to the same in-range address in the same cycle returns the merged word in stage 1. Enabled bytes come from wr_data; other bytes come from the old contents.
- Undefined: the read returns the old word; no bypass mux is built.

Test Plan:
- Init clear, RAM_DEPTH=256:
  - Stimulus: release rst_n, then read addresses 0, 17 and 255 once init_busy=0.
  - Required: init_busy high for exactly 256 cycles; all three reads return 0x00000000 with rd_valid.
- Byte enables:
  - Stimulus: write 0xAABBCCDD, be=4'b1111 to addr 5; then write 0x11223344, be=4'b0101 to addr 5; then read addr 5.
  - Required: read returns 0xAA22CC44.
- Latency sweep:
  - Stimulus: for RD_LATENCY=1..4, write 0xDEADBEEF to addr 3 and read it.
  - Required: rd_valid pulses exactly RD_LATENCY cycles after the request.
  - Required: back-to-back reads of addr 3 and addr 4 (0x0000_0004) give consecutive valid cycles.
- Simultaneous read/write:
  - Stimulus: addr 9 holds 0x12345678; in one cycle, write 0xFFFFFFFF with be=4'b0011 and read addr 9.
  - Required: without the macro, 0x12345678; with MEM_RAW_BYPASS_EN, 0x1234FFFF.
  - Required: a later read of addr 9 gives 0x1234FFFF in both builds.
- Mid-clear reset and clear_req:
  - Stimulus: assert rst_n=0 at clear cycle 100.
  - Required: the clear restarts and takes a full 256 cycles; reads during CLEAR produce no rd_valid.
  - Stimulus: after IDLE, write 0x55 to addr 200, pulse clear_req, wait, then read addr 200.
  - Required: the read returns 0.
- Out of range, RAM_DEPTH=200:
  - Stimulus: write 0xCAFE to addr 210, then read addr 210.
  - Required: rd_valid=1, rd_data=0; no in-range word is modified.
